// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: serves fetch from a LINES x (8*BEATS)-byte
// flop array and refills a whole line with a BEATS-beat 64-bit burst on a miss.

package icache_dm_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;
endpackage

module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int LINES = 16,
   parameter int BEATS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  ibus_req_t   ibus_req,
   output ibus_resp_t  ibus_resp,
   input  logic        flush,
   output logic        mem_req_valid,
   output logic [63:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_data,
   input  logic        mem_resp_last
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int BEAT_W = $clog2(BEATS);
   localparam int OFF_W  = 3 + BEAT_W;
   localparam int TAG_W  = 64 - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_e;

   state_e            state_q, state_d;
   logic [63:0]       addr_q, addr_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [63:0]       data_q [LINES][BEATS];
   logic [63:0]       data_d [LINES][BEATS];
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              flush_pend_q, flush_pend_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  lookup_tag;
   logic [BEAT_W-1:0] rd_beat;
   logic [63:0]       rd_beat_data;
   logic              hit;

   // All array reads use the latched address, never the live request.
   assign idx          = addr_q[OFF_W +: IDX_W];
   assign lookup_tag   = addr_q[63 -: TAG_W];
   assign rd_beat      = addr_q[3 +: BEAT_W];
   assign rd_beat_data = data_q[idx][rd_beat];
   assign hit          = valid_q[idx] && (tag_q[idx] == lookup_tag);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d      = state_q;
      addr_d       = addr_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      beat_d       = beat_q;
      flush_pend_d = flush_pend_q;
      rdata_d      = rdata_q;

      unique case (state_q)
         IDLE: begin
            if (flush) valid_d = '0;
            if (ibus_req.valid) begin
               addr_d  = ibus_req.addr;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (flush) begin
               valid_d = '0;
               state_d = IDLE;
            end else if (!ibus_req.valid || ibus_req.addr != addr_q) begin
               state_d = IDLE;
            end else if (hit) begin
               rdata_d = addr_q[2] ? rd_beat_data[63:32] : rd_beat_data[31:0];
               state_d = RESP;
            end else begin
               beat_d  = '0;
               state_d = REFILL;
            end
         end
         REFILL: begin
            if (flush) flush_pend_d = 1'b1;
            if (mem_resp_valid) begin
               data_d[idx][beat_q] = mem_resp_data;
               beat_d              = beat_q + BEAT_W'(1);
               // The last beat is trusted as-is; the counter only steers the write.
               if (mem_resp_last) begin
                  tag_d[idx]   = lookup_tag;
                  valid_d[idx] = 1'b1;
                  beat_d       = '0;
                  if (flush_pend_q || flush) begin
                     valid_d      = '0;
                     flush_pend_d = 1'b0;
                     state_d      = IDLE;
                  end else begin
                     state_d = LOOKUP;
                  end
               end
            end
         end
         RESP: begin
            if (flush) valid_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         valid_q      <= '0;
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
         rdata_q      <= rdata_d;
      end
   end

   // NOTE: tag and data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign ibus_resp.addr_ok = (state_q == RESP);
   assign ibus_resp.data_ok = (state_q == RESP);
   assign ibus_resp.data    = rdata_q;

   assign mem_req_valid = (state_q == REFILL);
   assign mem_req_addr  = mem_req_valid ? {addr_q[63:OFF_W], OFF_W'(0)} : '0;

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the fetch-stage program counter (ibus master) and the memory bus (burst read slave). It serves ibus requests from a 16-line × 32-byte array and refills whole lines on a miss with a 4-beat, 64-bit burst. Address changes and `flush` (FENCE.I) abandon or invalidate stale work so that fetch never receives data for an address it no longer requests.

## Interface
- `LINES`, 16: number of lines; power of two; index width = log2(LINES).
- `BEATS`, 4: 64-bit beats per line; line = 8·BEATS bytes (32 B by default).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ibus_req`  in  ibus_req_t  `.valid` and `.addr[63:0]` from the PC stage; `addr[1:0]` is always 00 and is ignored.
- `ibus_resp`  out  ibus_resp_t  `.addr_ok`, `.data_ok`, `.data[31:0]`; both ok bits pulse together for one cycle.
- `flush`  in  1  single-cycle pulse; invalidates every line.
- `mem_req_valid`  out  1  burst read request; held until the last beat is received.
- `mem_req_addr`  out  64  line-aligned address (`addr[4:0]` = 0).
- `mem_resp_valid`  in  1  beat valid.
- `mem_resp_data`  in  64  beat data; beats arrive in ascending address order.
- `mem_resp_last`  in  1  marks the final beat (the BEATS-th).

## Operation
- Address split (defaults): offset `[4:0]`, beat `[4:3]`, word `[2]`, index `[8:5]`, tag `[63:9]` (55 bits).
- Storage: per line a valid bit, a tag, and BEATS×64 data, all in flops. Arrays are read combinationally from the latched address.
- Returned word: `data = word ? beat_data[63:32] : beat_data[31:0]`.
- FSM states: IDLE, LOOKUP, REFILL, RESP.
  - IDLE: if `ibus_req.valid`, latch `addr` and go to LOOKUP.
  - LOOKUP: if `ibus_req.valid` is 0 or `ibus_req.addr` ≠ the latched address, go to IDLE with no response. Otherwise, on a hit (valid and tag match), register the data and go to RESP. On a miss, go to REFILL.
  - REFILL: drive `mem_req_valid`=1 with `mem_req_addr` = the line-aligned latched address. Each `mem_resp_valid` writes beat counter k (0..BEATS-1) into the data array and increments k. On `mem_resp_last`, write the tag, set the valid bit, drop `mem_req_valid`, and go to LOOKUP.
  - RESP: `addr_ok`=`data_ok`=1 for exactly this cycle. `ibus_req` is ignored in this cycle. Next state is IDLE.
- The victim line is always the indexed line; no write-back is needed.
- `flush`:
  - In IDLE, LOOKUP or RESP: clear all valid bits at that edge. A flush in LOOKUP forces IDLE and suppresses the response; a flush in RESP does not cancel the response already being driven.
  - In REFILL: set `flush_pend`. On refill completion, clear all valid bits (including the newly filled line), clear `flush_pend`, and go to IDLE.
- A refill is never aborted by an address change. The line is installed, then LOOKUP re-checks the address.
- A `mem_resp_valid` outside REFILL is ignored. `mem_resp_last` is trusted, independent of the beat counter.

## Timing
- Reset (asynchronous) values:
  - `ibus_resp.addr_ok`/`data_ok` = 0, `ibus_resp.data` = 0.
  - `mem_req_valid` = 0, `mem_req_addr` = 0.
  - All valid bits = 0, state = IDLE, beat counter = 0, `flush_pend` = 0.
  - Tags and data are not reset.
- Hit latency: `valid` high in cycle 0 (IDLE) → LOOKUP in cycle 1 → response in cycle 2.
- Miss latency: cycle 0 IDLE, cycle 1 LOOKUP, REFILL from cycle 2 with `mem_req_valid` high. If the last beat arrives in cycle L, LOOKUP is in L+1 and the response in L+2.
- Throughput: the PC stage drops `valid` at the response edge. The next request is accepted in IDLE at the earliest 1 cycle after RESP.
- Reset asserted mid-REFILL takes effect immediately: `mem_req_valid` falls and the cache comes back empty. Beats still in flight after reset are ignored (state is IDLE).

## Test plan
- Cold miss: after reset, request 0x8000_0000 with memory line beats 0x11..0x44 patterns → `mem_req_addr`=0x8000_0000, 4 beats, response in cycle L+2 with `data` = low word of beat 0.
- Hit:
  - Then request 0x8000_000C → response 2 cycles after `valid`, `data` = high word of beat 1, `mem_req_valid` stays 0.
  - Sweep 0x8000_0000..0x8000_001C → 8 hits with the correct words.
- Conflict: request 0x8000_0200 (same index 0, different tag) → miss and refill. A following request to 0x8000_0000 misses again.
- Jump mid-refill: during REFILL of 0x8000_0040, change `ibus_req.addr` to 0x8000_0100 → no response for 0x40. The 0x40 line is installed, then 0x100 is looked up, refilled, and responded.
- Flush:
  - Flush in IDLE → next request to a previously cached line issues `mem_req_valid`.
  - Flush during REFILL → refill completes, no response in that pass, line invalid, and the request re-misses.
- Reset mid-REFILL after 2 beats → outputs return to their reset values within the same cycle, and the next request misses.
